greg_file: RTL and testbench
============================

Name: greg_file

Overview:
- General register file: the responder for the GREG read interface driven by the fetch/decode stage.
- Services three read ports (A, B, X) and one write-back port.
- Publishes the last written register as the bypass pair consumed by fetch/decode.
- Holds a pending-write scoreboard so decode can stall on registers still in flight.

Parameters:
- WORD_LENGTH, 32, data word width.
- NUM_REGS, 16, number of general registers.
- REG_ID_WIDTH, 4, register index width (log2 NUM_REGS).

Ports:
- clk  in  1  stage clock.
- rst  in  1  synchronous reset, active-high.
- inRegIdA  in  4  read port A register id.
- outRegValA  out  WORD_LENGTH  read port A value.
- inRegIdB  in  4  read port B register id.
- outRegValB  out  WORD_LENGTH  read port B value.
- inRegIdX  in  4  read port X register id.
- outRegValX  out  WORD_LENGTH  read port X value.
- wrEnable  in  1  write-back strobe.
- wrRegId  in  4  write-back target.
- wrRegVal  in  WORD_LENGTH  write-back data.
- rsvEnable  in  1  reserve target register; issued by the decode of an instruction that will write it.
- rsvRegId  in  4  register to reserve.
- bypassRegId  out  4  id of the register written in the previous cycle; 0 if none.
- bypassRegVal  out  WORD_LENGTH  value of that write.
- stall  out  1  a read port references a pending register.
- rsvErr  out  1  sticky: reserve hit an already-pending register.

Behaviour:
- Reset (rst=1 at posedge clk):
  - All registers, pending mask, bypassRegId/Val and rsvErr clear to 0.
  - Writes and reserves presented in the reset cycle are discarded.
  - Reset mid-operation drops every outstanding reservation.
- Register 0:
  - Always reads 0.
  - Writes and reserves to id 0 are ignored: no array change, no pending bit, no bypass update.
- Reads are combinational, zero latency.
  - Write-through: if wrEnable and wrRegId==id and id!=0, the port returns wrRegVal in the same cycle.
  - Otherwise the port returns the array value.
- Write: array[wrRegId] <= wrRegVal at posedge when wrEnable and wrRegId!=0.
- Bypass pair is registered, 1-cycle latency.
  - After a write to id r: bypassRegId=r and bypassRegVal=value for exactly one cycle.
  - Otherwise bypassRegId=0 and bypassRegVal=0. Consumers compare ids, so id 0 is harmless.
- Scoreboard: NUM_REGS-bit pending mask.
  - Reserve with id!=0 sets bit rsvRegId.
  - Write clears bit wrRegId.
  - Same id reserved and written in the same cycle: the set wins (newer producer); the written data still lands in the array.
  - Reserving an already-pending bit sets rsvErr. rsvErr stays set until reset.
- stall = OR over ports p of (pending[id_p] and not (wrEnable and wrRegId==id_p)).
  - Combinational.
  - An id of 0 never stalls.
  - A register being written this cycle does not stall, because its value is forwarded by write-through.
- Arithmetic: none. Ids are unsigned; out-of-range ids cannot occur with NUM_REGS=16.

Decomposition:
- Shared defines/package holds:
  - WORD_LENGTH, REG_ID_WIDTH, NUM_REGS.
  - ZERO word constant.
  - REG_ZERO id constant (0).
- One sub-module: greg_scoreboard.
  - Contains the pending mask, rsvErr and stall logic.
  - Inputs: rsv/wr strobes and ids, the three read ids.
- Array, write-through and bypass register live in greg_file.

Test Plan:
- Reset then read ids 1,5,15 -> all ports 0; bypassRegId=0; stall=0; rsvErr=0.
- Write r3=0xDEADBEEF while reading A=3 in the same cycle -> outRegValA=0xDEADBEEF in that cycle. Next cycle bypassRegId=3, bypassRegVal=0xDEADBEEF. Cycle after that: bypassRegId=0.
- Write r0=0x12345678 -> reads of id 0 return 0; bypassRegId stays 0.
- Reserve r7, then read B=7 -> stall=1. Write r7=0x55 -> stall=0 in the write cycle with outRegValB=0x55. Bit stays clear afterwards.
- Reserve r9 and write r9=0xAA in the same cycle -> r9 reads 0xAA, pending[9] stays set, read X=9 stalls. Reserve r9 again -> rsvErr=1 and stays 1.
- Reserve r2 and r4, assert rst -> pending cleared, stall=0; reads of r2/r4 return 0.

Source files
------------

// File: rtl/greg_file_pkg.sv
// Shared widths, types and constants for the general register file.
package greg_file_pkg;

    localparam int unsigned WORD_LENGTH  = 32;
    localparam int unsigned NUM_REGS     = 16;
    localparam int unsigned REG_ID_WIDTH = 4;

    typedef logic [WORD_LENGTH-1:0]  word_t;
    typedef logic [REG_ID_WIDTH-1:0] reg_id_t;
    typedef logic [NUM_REGS-1:0]     reg_mask_t;

    typedef struct packed {
        reg_id_t id;
        word_t   val;
    } bypass_t;

    localparam word_t   ZERO     = '0;
    localparam reg_id_t REG_ZERO = '0;

    // Register 0 is hardwired: a strobe aimed at it has no effect anywhere.
    function automatic logic live_id(logic en, reg_id_t id);
        return en && (id != REG_ZERO);
    endfunction

endpackage

// File: rtl/greg_file_if.sv
// GREG read/write-back/reserve bus between fetch/decode (master) and the register file (slave).
interface greg_file_if;
    import greg_file_pkg::*;

    reg_id_t inRegIdA;
    word_t   outRegValA;
    reg_id_t inRegIdB;
    word_t   outRegValB;
    reg_id_t inRegIdX;
    word_t   outRegValX;
    logic    wrEnable;
    reg_id_t wrRegId;
    word_t   wrRegVal;
    logic    rsvEnable;
    reg_id_t rsvRegId;
    reg_id_t bypassRegId;
    word_t   bypassRegVal;
    logic    stall;
    logic    rsvErr;

    modport master (
        output inRegIdA, inRegIdB, inRegIdX,
        output wrEnable, wrRegId, wrRegVal,
        output rsvEnable, rsvRegId,
        input  outRegValA, outRegValB, outRegValX,
        input  bypassRegId, bypassRegVal, stall, rsvErr
    );

    modport slave (
        input  inRegIdA, inRegIdB, inRegIdX,
        input  wrEnable, wrRegId, wrRegVal,
        input  rsvEnable, rsvRegId,
        output outRegValA, outRegValB, outRegValX,
        output bypassRegId, bypassRegVal, stall, rsvErr
    );

endinterface

// File: rtl/greg_scoreboard.sv
// Pending-write mask: reserved at decode, released on write-back; drives the decode stall.
module greg_scoreboard
    import greg_file_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    rsv_en,
    input  reg_id_t rsv_id,
    input  logic    wr_en,
    input  reg_id_t wr_id,
    input  reg_id_t rd_id_a,
    input  reg_id_t rd_id_b,
    input  reg_id_t rd_id_x,
    output logic    stall,
    output logic    rsv_err
);

    reg_mask_t pending_q;
    reg_mask_t pending_d;
    logic      rsv_err_d;

    // Clear on write first so a same-cycle reserve (newer producer) wins.
    always_comb begin
        pending_d = pending_q;
        rsv_err_d = rsv_err;
        if (live_id(wr_en, wr_id)) begin
            pending_d[wr_id] = 1'b0;
        end
        if (live_id(rsv_en, rsv_id)) begin
            pending_d[rsv_id] = 1'b1;
            if (pending_q[rsv_id]) begin
                rsv_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            rsv_err   <= 1'b0;
        end else begin
            pending_q <= pending_d;
            rsv_err   <= rsv_err_d;
        end
    end

    // A register being written this cycle is forwarded, so it does not stall.
    function automatic logic port_stall(reg_id_t id, reg_mask_t pend, logic wen, reg_id_t wid);
        return (id != REG_ZERO) && pend[id] && !(wen && (wid == id));
    endfunction

    assign stall = port_stall(rd_id_a, pending_q, wr_en, wr_id)
                 | port_stall(rd_id_b, pending_q, wr_en, wr_id)
                 | port_stall(rd_id_x, pending_q, wr_en, wr_id);

endmodule

// File: rtl/greg_file.sv
// General register file: three write-through read ports, one write-back port,
// a one-cycle bypass pair and the pending-write scoreboard.
module greg_file
    import greg_file_pkg::*;
(
    input logic        clk,
    input logic        rst,
    greg_file_if.slave bus
);

    word_t   regs [NUM_REGS];
    bypass_t bypass_q;
    logic    wr_live_c;

    assign wr_live_c = live_id(bus.wrEnable, bus.wrRegId);

    function automatic word_t read_port(reg_id_t id, word_t arr_val, logic wr_live,
                                        reg_id_t wr_id, word_t wr_val);
        if (id == REG_ZERO) begin
            return ZERO;
        end
        if (wr_live && (wr_id == id)) begin
            return wr_val;
        end
        return arr_val;
    endfunction

    assign bus.outRegValA = read_port(bus.inRegIdA, regs[bus.inRegIdA], wr_live_c, bus.wrRegId, bus.wrRegVal);
    assign bus.outRegValB = read_port(bus.inRegIdB, regs[bus.inRegIdB], wr_live_c, bus.wrRegId, bus.wrRegVal);
    assign bus.outRegValX = read_port(bus.inRegIdX, regs[bus.inRegIdX], wr_live_c, bus.wrRegId, bus.wrRegVal);

    // Array and bypass pair; bypass holds a write for exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs     <= '{default: ZERO};
            bypass_q <= '0;
        end else if (wr_live_c) begin
            regs[bus.wrRegId] <= bus.wrRegVal;
            bypass_q          <= '{id: bus.wrRegId, val: bus.wrRegVal};
        end else begin
            bypass_q <= '0;
        end
    end

    assign bus.bypassRegId  = bypass_q.id;
    assign bus.bypassRegVal = bypass_q.val;

    greg_scoreboard u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .rsv_en  (bus.rsvEnable),
        .rsv_id  (bus.rsvRegId),
        .wr_en   (bus.wrEnable),
        .wr_id   (bus.wrRegId),
        .rd_id_a (bus.inRegIdA),
        .rd_id_b (bus.inRegIdB),
        .rd_id_x (bus.inRegIdX),
        .stall   (bus.stall),
        .rsv_err (bus.rsvErr)
    );

endmodule

// File: tb/tb_greg_file.sv
// Scoreboard bench for greg_file: driver pushes model expectations, monitor compares at negedge.
module tb_greg_file;
    import greg_file_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    greg_file_if bus();

    greg_file dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit      known;
        int      cyc;
        word_t   a;
        word_t   b;
        word_t   x;
        reg_id_t byp_id;
        word_t   byp_val;
        logic    stall;
        logic    err;
    } exp_t;

    exp_t exp_q[$];

    // Behavioural model state
    word_t   m_regs [NUM_REGS];
    bit      m_pend [NUM_REGS];
    reg_id_t m_byp_id;
    word_t   m_byp_val;
    bit      m_err;
    bit      m_known = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int cycle_n  = 0;
    bit drv_done = 1'b0;

    function automatic word_t m_read(reg_id_t id, logic we, reg_id_t wid, word_t wv);
        if (id == 4'd0) return 32'd0;
        if (we && wid == id) return wv;
        return m_regs[id];
    endfunction

    function automatic logic m_port_stall(reg_id_t id, logic we, reg_id_t wid);
        if (id == 4'd0) return 1'b0;
        if (we && wid == id) return 1'b0;
        return m_pend[id];
    endfunction

    task automatic cyc(input logic r, input logic we, input reg_id_t wid, input word_t wv,
                       input logic re, input reg_id_t rid,
                       input reg_id_t a, input reg_id_t b, input reg_id_t x);
        exp_t e;
        bit   was;
        @(posedge clk);
        #1;
        cycle_n++;
        rst           = r;
        bus.wrEnable  = we;
        bus.wrRegId   = wid;
        bus.wrRegVal  = wv;
        bus.rsvEnable = re;
        bus.rsvRegId  = rid;
        bus.inRegIdA  = a;
        bus.inRegIdB  = b;
        bus.inRegIdX  = x;

        e.known   = m_known;
        e.cyc     = cycle_n;
        e.a       = m_read(a, we, wid, wv);
        e.b       = m_read(b, we, wid, wv);
        e.x       = m_read(x, we, wid, wv);
        e.byp_id  = m_byp_id;
        e.byp_val = m_byp_val;
        e.stall   = m_port_stall(a, we, wid) | m_port_stall(b, we, wid) | m_port_stall(x, we, wid);
        e.err     = m_err;
        exp_q.push_back(e);

        // Advance the model to the state after this clock edge
        if (r) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                m_regs[i] = 32'd0;
                m_pend[i] = 1'b0;
            end
            m_byp_id  = 4'd0;
            m_byp_val = 32'd0;
            m_err     = 1'b0;
            m_known   = 1'b1;
        end else begin
            was = m_pend[rid];
            if (we && wid != 4'd0) begin
                m_regs[wid] = wv;
                m_pend[wid] = 1'b0;
                m_byp_id    = wid;
                m_byp_val   = wv;
            end else begin
                m_byp_id  = 4'd0;
                m_byp_val = 32'd0;
            end
            if (re && rid != 4'd0) begin
                if (was) m_err = 1'b1;
                m_pend[rid] = 1'b1;
            end
        end
    endtask

    task automatic check(input string nm, input int c, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h exp=%h", nm, c, got, exp);
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.known) begin
                    check("outRegValA",   e.cyc, bus.outRegValA, e.a);
                    check("outRegValB",   e.cyc, bus.outRegValB, e.b);
                    check("outRegValX",   e.cyc, bus.outRegValX, e.x);
                    check("bypassRegId",  e.cyc, 32'(bus.bypassRegId), 32'(e.byp_id));
                    check("bypassRegVal", e.cyc, bus.bypassRegVal, e.byp_val);
                    check("stall",        e.cyc, 32'(bus.stall), 32'(e.stall));
                    check("rsvErr",       e.cyc, 32'(bus.rsvErr), 32'(e.err));
                end
            end
        end
    end

    // Driver
    initial begin
        rst           = 1'b1;
        bus.wrEnable  = 1'b0;
        bus.wrRegId   = 4'd0;
        bus.wrRegVal  = 32'd0;
        bus.rsvEnable = 1'b0;
        bus.rsvRegId  = 4'd0;
        bus.inRegIdA  = 4'd0;
        bus.inRegIdB  = 4'd0;
        bus.inRegIdX  = 4'd0;

        cyc(1, 0, 0, 0,            0, 0, 0, 0, 0);
        cyc(1, 1, 5, 32'h1111_1111, 1, 6, 1, 5, 15);
        cyc(0, 0, 0, 0,            0, 0, 1, 5, 15);
        // write-through then bypass for one cycle
        cyc(0, 1, 3, 32'hDEAD_BEEF, 0, 0, 3, 0, 0);
        cyc(0, 0, 0, 0,            0, 0, 3, 0, 0);
        cyc(0, 0, 0, 0,            0, 0, 3, 3, 3);
        // register 0 writes are ignored
        cyc(0, 1, 0, 32'h1234_5678, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0,            0, 0, 0, 0, 0);
        // reserve, stall, release by write
        cyc(0, 0, 0, 0,            1, 7, 0, 0, 0);
        cyc(0, 0, 0, 0,            0, 0, 0, 7, 0);
        cyc(0, 1, 7, 32'h55,       0, 0, 0, 7, 0);
        cyc(0, 0, 0, 0,            0, 0, 0, 7, 0);
        // reserve and write same id, then double reserve
        cyc(0, 1, 9, 32'hAA,       1, 9, 0, 0, 0);
        cyc(0, 0, 0, 0,            0, 0, 0, 0, 9);
        cyc(0, 0, 0, 0,            1, 9, 0, 0, 0);
        cyc(0, 0, 0, 0,            0, 0, 0, 0, 9);
        cyc(0, 0, 0, 0,            1, 0, 0, 0, 0);
        // reset drops reservations and data
        cyc(0, 0, 0, 0,            1, 2, 0, 0, 0);
        cyc(0, 0, 0, 0,            1, 4, 2, 4, 0);
        cyc(1, 1, 2, 32'h77,       1, 4, 2, 4, 0);
        cyc(0, 0, 0, 0,            0, 0, 2, 4, 9);

        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(59) == 0) ? 1'b1 : 1'b0,
                1'($urandom_range(1)), 4'($urandom), $urandom,
                ($urandom_range(9) < 3) ? 1'b1 : 1'b0, 4'($urandom),
                4'($urandom), 4'($urandom), 4'($urandom));
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drv_done = 1'b1;
    end

    initial begin
        wait (drv_done);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain pending=%0d required=0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d passed=%0d", n_checks, n_pass);
        $fatal(1, "timeout");
    end

endmodule
